// File: rtl/sercmp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
package sercmp_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sercmp_state_e;

   localparam int unsigned RES_W = 3;

   // One-hot result, bit order {greater, lesser, equal}
   localparam logic [RES_W-1:0] RES_EQ = 3'b001;
   localparam logic [RES_W-1:0] RES_LT = 3'b010;
   localparam logic [RES_W-1:0] RES_GT = 3'b100;

   // Map the held decision onto the one-hot result encoding
   function automatic logic [RES_W-1:0] sercmp_result(input logic decided,
                                                      input logic gt,
                                                      input logic lt);
      logic [RES_W-1:0] res;
      if (!decided) begin
         res = RES_EQ;
      end else if (gt && !lt) begin
         res = RES_GT;
      end else begin
         res = RES_LT;
      end
      return res;
   endfunction

endpackage : sercmp_pkg

// File: rtl/cmp_bit_cell.sv
// Single bit-pair compare decision (pure combinational).
module cmp_bit_cell (
   input  logic a_bit,
   input  logic b_bit,
   output logic bit_gt,
   output logic bit_lt,
   output logic bit_eq
);

   // A bit pair is decisive only when the bits differ
   always_comb begin
      bit_gt = a_bit & ~b_bit;
      bit_lt = ~a_bit & b_bit;
      bit_eq = ~(a_bit ^ b_bit);
   end

endmodule : cmp_bit_cell

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, operands arrive MSB first.
// The first differing bit pair decides the result; later bits cannot change it.
// Optional build macro SERCMP_EARLY_EXIT_EN: finish as soon as a decision is
// made instead of consuming all WIDTH bit pairs.
module serial_magnitude_comparator
   import sercmp_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic a_bit,
   input  logic b_bit,
   input  logic bit_valid,
   output logic bit_ready,
   output logic busy,
   output logic done,
   output logic equal,
   output logic greater,
   output logic lesser
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   sercmp_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             decided_q, decided_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic [RES_W-1:0] res_q, res_d;
   logic             bit_ready_q, bit_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             bit_gt_c, bit_lt_c, bit_eq_c;
   logic             beat_c;
   logic             last_beat_c;
   logic             exit_c;

   cmp_bit_cell u_cmp_bit_cell (
      .a_bit  (a_bit),
      .b_bit  (b_bit),
      .bit_gt (bit_gt_c),
      .bit_lt (bit_lt_c),
      .bit_eq (bit_eq_c)
   );

   // Beat acceptance and end-of-operand detection
   always_comb begin
      beat_c      = (state_q == SHIFT) && bit_valid;
      last_beat_c = beat_c && (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SERCMP_EARLY_EXIT_EN
      exit_c      = beat_c && !decided_q && !bit_eq_c;
`else
      exit_c      = 1'b0;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_beat_c || exit_c) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cnt_d     = cnt_q;
      decided_d = decided_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      res_d     = res_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d     = '0;
               decided_d = 1'b0;
               gt_d      = 1'b0;
               lt_d      = 1'b0;
               res_d     = '0;
            end
         end
         SHIFT: begin
            if (beat_c) begin
               if (cnt_q != CNT_W'(WIDTH)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               // Only the first differing pair is latched
               if (!decided_q && !bit_eq_c) begin
                  gt_d      = bit_gt_c;
                  lt_d      = bit_lt_c;
                  decided_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase

      // Publish the result together with the done strobe
      if (state_d == DONE) begin
         res_d = sercmp_result(decided_d, gt_d, lt_d);
      end

      bit_ready_d = (state_d == SHIFT);
      busy_d      = (state_d == SHIFT);
      done_d      = (state_d == DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         decided_q   <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
         res_q       <= '0;
         bit_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         decided_q   <= decided_d;
         gt_q        <= gt_d;
         lt_q        <= lt_d;
         res_q       <= res_d;
         bit_ready_q <= bit_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bit_ready = bit_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign greater   = res_q[2];
   assign lesser    = res_q[1];
   assign equal     = res_q[0];

endmodule : serial_magnitude_comparator

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8 plus a WIDTH=1 instance).
module tb_serial_magnitude_comparator;

   localparam int W = 8;

   typedef struct {
      logic [2:0] res;
      int         done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic a_bit = 1'b0;
   logic b_bit = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_ready, busy, done, equal, greater, lesser;

   logic s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
   logic ready1, busy1, done1, eq1, gt1, lt1;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   in_reset = 1'b1;
   logic [2:0] held = 3'b000;
   exp_t sb_q[$];
   int   stall[W];

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_bit(a_bit), .b_bit(b_bit),
      .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy), .done(done),
      .equal(equal), .greater(greater), .lesser(lesser)
   );

   serial_magnitude_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .a_bit(a1), .b_bit(b1),
      .bit_valid(v1), .bit_ready(ready1), .busy(busy1), .done(done1),
      .equal(eq1), .greater(gt1), .lesser(lt1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations on done, checks clearing and holding otherwise
   always @(negedge clk) begin
      exp_t e;
      if (in_reset) begin
         held = 3'b000;
      end else if (done) begin
         if (sb_q.size() == 0) begin
            check("done_unexpected", {31'd0, done}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("result", {29'd0, greater, lesser, equal}, {29'd0, e.res});
            check("done_cycle", cyc, e.done_cyc);
            held = e.res;
         end
      end else if (busy) begin
         check("cleared_in_shift", {29'd0, greater, lesser, equal}, 32'd0);
         check("ready_in_shift", {31'd0, bit_ready}, 32'd1);
      end else begin
         check("hold_idle", {29'd0, greater, lesser, equal}, {29'd0, held});
         check("ready_idle", {31'd0, bit_ready}, 32'd0);
      end
   end

   // Driver: issues one comparison using the stall[] pattern; poke pulses start while busy/DONE
   task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
      exp_t e;
      int   k, beats, stalls, t, h;
      if (a > b)      e.res = 3'b100;
      else if (a < b) e.res = 3'b010;
      else            e.res = 3'b001;
      beats = W;
`ifdef SERCMP_EARLY_EXIT_EN
      if (a != b) begin
         h = 0;
         for (int i = 0; i < W; i++) if (a[i] != b[i]) h = i;
         beats = W - h;
      end
`else
      h = 0;
`endif
      stalls = 0;
      for (int j = 0; j < beats; j++) stalls += stall[j];

      @(negedge clk);
      start     = 1'b1;
      bit_valid = 1'($urandom_range(0, 1));
      k         = cyc;
      e.done_cyc = k + 1 + stalls + beats;
      sb_q.push_back(e);

      for (int j = 0; j < beats; j++) begin
         for (int s = 0; s < stall[j]; s++) begin
            @(negedge clk);
            start     = poke && (cyc == k + 3);
            bit_valid = 1'b0;
            a_bit     = 1'($urandom_range(0, 1));
            b_bit     = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         start     = poke && (cyc == k + 3);
         bit_valid = 1'b1;
         a_bit     = a[W-1-j];
         b_bit     = b[W-1-j];
      end

      @(negedge clk);
      bit_valid = 1'b0;
      start     = poke;
      t = 0;
      while (!done && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      if (poke) check("no_restart", {31'd0, busy}, 32'd0);
   endtask

   task automatic clear_stalls();
      for (int j = 0; j < W; j++) stall[j] = 0;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      clear_stalls();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, bit_ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", {29'd0, greater, lesser, equal}, 32'd0);
      check("rst_w1_done", {31'd0, done1}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      in_reset = 1'b0;

      // Directed: equal, greater, lesser with stalls, start pokes
      run_cmp(8'hA5, 8'hA5, 1'b0);
      run_cmp(8'h80, 8'h7F, 1'b0);
      stall[2] = 1;
      stall[3] = 1;
      run_cmp(8'h3C, 8'h3D, 1'b0);
      clear_stalls();
      run_cmp(8'h12, 8'h34, 1'b1);
      run_cmp(8'hFF, 8'h00, 1'b0);
      run_cmp(8'h00, 8'h01, 1'b0);

      // Reset in the middle of a comparison
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         bit_valid = 1'b1;
         a_bit = 1'b1;
         b_bit = 1'b0;
         @(negedge clk);
      end
      rst_n    = 1'b0;
      in_reset = 1'b1;
      bit_valid = 1'b0;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ready", {31'd0, bit_ready}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", {29'd0, greater, lesser, equal}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      in_reset = 1'b0;
      run_cmp(8'h01, 8'h80, 1'b0);

      // Randomized comparisons with random handshake stalls
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom);
         rb = (n % 3 == 0) ? ra : W'($urandom);
         if (n % 5 == 1) rb = ra ^ W'(1);
         for (int j = 0; j < W; j++)
            stall[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_cmp(ra, rb, 1'(n % 7 == 3));
      end
      clear_stalls();

      // WIDTH=1 instance: A=1,B=0 then A=0,B=0
      @(negedge clk);
      s1 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      check("w1_ready", {31'd0, ready1}, 32'd1);
      v1 = 1'b1;
      a1 = 1'b1;
      b1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      check("w1_gt_done", {31'd0, done1}, 32'd1);
      check("w1_gt_result", {29'd0, gt1, lt1, eq1}, 32'h4);
      @(negedge clk);
      check("w1_gt_hold", {29'd0, gt1, lt1, eq1, done1}, 32'h8);
      s1 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      v1 = 1'b1;
      a1 = 1'b0;
      b1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      check("w1_eq_done", {31'd0, done1}, 32'd1);
      check("w1_eq_result", {29'd0, gt1, lt1, eq1}, 32'h1);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_magnitude_comparator

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial unsigned magnitude comparator for two WIDTH-bit operands. Operand bits arrive MSB-first, one pair per accepted beat, over a valid/ready handshake. The block latches the first differing bit pair and reports a registered one-hot equal/greater/lesser result with a single-cycle done strobe. It is the sequential multi-bit consumer of per-bit compare decisions, sitting between a serialising front end and control logic that needs a magnitude decision.

## Interface
- WIDTH, 8: operand width in bits (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  one clock; reset is synchronous and active-low.
- start  input  1  begin a comparison; accepted only in IDLE.
- a_bit  input  1  operand A bit, MSB first.
- b_bit  input  1  operand B bit, MSB first.
- bit_valid  input  1  a_bit/b_bit valid this cycle.
- bit_ready  output  1  block accepts a bit pair this cycle.
- busy  output  1  comparison in progress (SHIFT state).
- done  output  1  one-cycle strobe; result valid.
- equal  output  1  A == B.
- greater  output  1  A > B.
- lesser  output  1  A < B.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: bit_ready=0, busy=0. If start=1: clear equal/greater/lesser, clear the decided flag, zero the bit counter, and go to SHIFT.
- SHIFT: bit_ready=1, busy=1. A beat is accepted when bit_valid && bit_ready. On each accepted beat:
  - Increment the counter.
  - If no decision is held yet and a_bit≠b_bit, latch gt = a_bit & ~b_bit, lt = ~a_bit & b_bit, and set decided.
  - Later bits do not alter a held decision.
- When the WIDTH-th beat is accepted, go to DONE.
- DONE (one cycle): done=1. Drive greater=gt, lesser=lt, equal=~decided. Exactly one is 1. Then go to IDLE.
- Result outputs hold their value until the next accepted start, which clears them.
- start is ignored outside IDLE.
- bit_valid is ignored outside SHIFT.
- Counter width is $clog2(WIDTH+1). The counter never wraps: it stops at WIDTH.
- Reset (rst_n=0 at a clock edge, any state):
  - State goes to IDLE.
  - done, busy, bit_ready, equal, greater, lesser all go to 0.
  - The counter and decided flag are cleared.
  - A comparison in progress is discarded.

## Timing
- All outputs are registered. The reset value of every output is 0.
- Cycle 0: start sampled in IDLE. Cycle 1: busy=1, bit_ready=1.
- With bit_valid held high, beats are accepted in cycles 1..WIDTH and done=1 in cycle WIDTH+1. Latency from start to done is WIDTH+1 cycles.
- Each cycle with bit_valid=0 in SHIFT adds one cycle of latency.
- The earliest next start is the cycle after done (IDLE).
- A start asserted in the DONE cycle is ignored.

## Configuration
- SERCMP_EARLY_EXIT_EN defined:
  - On the first accepted beat with a_bit≠b_bit, go to DONE on the next cycle.
  - done asserts the cycle after that beat. bit_ready is 0 from that cycle on.
  - Remaining operand bits are not consumed. The upstream source must abandon them.
  - An equal result still needs all WIDTH beats.
- SERCMP_EARLY_EXIT_EN undefined:
  - Exactly WIDTH beats are always consumed.
  - Latency depends only on the handshake, never on the data.

## Structure
- Package sercmp_pkg holds:
  - The state enum type (IDLE/SHIFT/DONE).
  - The result encoding localparams: RES_EQ, RES_GT, RES_LT as 3-bit one-hot {greater, lesser, equal}.
- One combinational sub-module, cmp_bit_cell, is natural. Inputs: a_bit, b_bit. Outputs: bit_gt, bit_lt, bit_eq. It is instantiated once in the datapath.

## Test plan
All scenarios use WIDTH=8.
- A=0xA5, B=0xA5, start at cycle 0, bit_valid always 1 -> done at cycle 9; equal=1, greater=0, lesser=0.
- A=0x80, B=0x7F -> greater=1. Without the macro, done at cycle 9. With SERCMP_EARLY_EXIT_EN, done at cycle 2 and bit_ready=0 from cycle 2.
- A=0x3C, B=0x3D, bit_valid low on cycles 3 and 5 -> lesser=1, done at cycle 11. The result holds after done until the next start, which clears it.
- Reset pulse at cycle 4 mid-SHIFT -> the next cycle shows all outputs 0 and state IDLE. A new start compares correctly from bit 0.
- start pulsed at cycles 3 and 9 (busy, DONE) -> ignored; there is no restart or result corruption.
- WIDTH=1: A=1, B=0 -> greater=1, done at cycle 2. A=0, B=0 -> equal=1.
